// File: rtl/operand_compare_seq_pkg.sv
// Shared definitions for the operand comparator.
//   state_t                  - FSM state encoding shared by the top level
//   DEFAULT_DEBOUNCE_CYCLES  - debounce length for the 50 MHz board clock
//   cnt_width()              - width of a counter that must hold 0..n
package operand_compare_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    COMPARE = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // 5 ms of stable level at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250_000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/operand_compare_seq_button_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the accepted 0->1 transition.
//   clk        system clock
//   rst        asynchronous reset, active-high
//   btn_raw    raw button pin, asynchronous to clk
//   btn_level  debounced (stable) button level
//   btn_press  one-cycle pulse when btn_level goes 0->1
module button_debounce
  import operand_compare_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; with = the synchroniser would collapse into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      btn_press <= 1'b0;
      if (sync_q2 != btn_level) begin
        // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level.
        if (cnt == CNT_LAST) begin
          btn_level <= sync_q2;
          cnt       <= '0;
          btn_press <= sync_q2;  // pulse on press only, never on release
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_compare_seq.sv
// Two-operand comparator for the lab board. Operand A then operand B are
// taken from the switch bank on debounced load presses, compared (signed or
// unsigned) and shown on one-hot less/equal/greater LEDs.
//   clk, rst                   clock, asynchronous active-high reset
//   sw[WIDTH-1:0]              switch bank (operand value)
//   btn_load, btn_clear        raw buttons
//   led_less/equal/greater     registered compare result, valid in SHOW
//   led_wait_a, led_wait_b     entry-status LEDs
//   opnd_a, opnd_b             latched operands for display
module operand_compare_seq
  import operand_compare_seq_pkg::*;
#(
  parameter int          WIDTH           = 8,
  parameter bit          SIGNED_MODE     = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic             led_less,
  output logic             led_equal,
  output logic             led_greater,
  output logic             led_wait_a,
  output logic             led_wait_b,
  output logic [WIDTH-1:0] opnd_a,
  output logic [WIDTH-1:0] opnd_b
);

  state_t state;
  logic   load_press;
  logic   clear_press;
  logic   load_level;
  logic   clear_level;
  logic   a_lt_b;
  logic   a_eq_b;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_load),
    .btn_level (load_level),
    .btn_press (load_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_clear),
    .btn_level (clear_level),
    .btn_press (clear_press)
  );

  // Only the press pulses drive the FSM; the held levels are not needed here.
  logic unused_levels;
  assign unused_levels = &{1'b0, load_level, clear_level};

  assign a_lt_b = SIGNED_MODE ? ($signed(opnd_a) < $signed(opnd_b))
                              : (opnd_a < opnd_b);
  assign a_eq_b = (opnd_a == opnd_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_A;
      opnd_a      <= '0;
      opnd_b      <= '0;
      led_less    <= 1'b0;
      led_equal   <= 1'b0;
      led_greater <= 1'b0;
    end else if (clear_press) begin
      // Clear outranks a simultaneous load in every state.
      state       <= WAIT_A;
      opnd_a      <= '0;
      opnd_b      <= '0;
      led_less    <= 1'b0;
      led_equal   <= 1'b0;
      led_greater <= 1'b0;
    end else begin
      case (state)
        WAIT_A: begin
          if (load_press) begin
            opnd_a <= sw;
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_press) begin
            opnd_b <= sw;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          led_less    <= a_lt_b;
          led_equal   <= a_eq_b;
          led_greater <= ~a_lt_b & ~a_eq_b;
          state       <= SHOW;
        end
        SHOW: begin
          // Operands stay on display until the next load overwrites them.
          if (load_press) begin
            led_less    <= 1'b0;
            led_equal   <= 1'b0;
            led_greater <= 1'b0;
            state       <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  assign led_wait_a = (state == WAIT_A);
  assign led_wait_b = (state == WAIT_B);

endmodule

// File: tb/tb_operand_compare_seq.sv
module tb_operand_compare_seq;

  localparam int W  = 8;
  localparam int DB = 4;

  typedef struct {
    logic [2:0]   leds;   // {less, equal, greater}
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_load = 1'b0;
  logic         btn_clear = 1'b0;

  // Index 0: unsigned instance, index 1: signed instance; same stimulus.
  logic         t_less[2];
  logic         t_equal[2];
  logic         t_greater[2];
  logic         t_wait_a[2];
  logic         t_wait_b[2];
  logic [W-1:0] t_opnd_a[2];
  logic [W-1:0] t_opnd_b[2];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  logic [2:0] prev_cmp[2];
  logic       prev_wb[2];
  int         leave_b_cyc[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    operand_compare_seq #(
      .WIDTH           (W),
      .SIGNED_MODE     (g == 1),
      .DEBOUNCE_CYCLES (DB)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw          (sw),
      .btn_load    (btn_load),
      .btn_clear   (btn_clear),
      .led_less    (t_less[g]),
      .led_equal   (t_equal[g]),
      .led_greater (t_greater[g]),
      .led_wait_a  (t_wait_a[g]),
      .led_wait_b  (t_wait_b[g]),
      .opnd_a      (t_opnd_a[g]),
      .opnd_b      (t_opnd_b[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: plain integer comparison of the operands as the mode reads them.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit signed_mode);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (signed_mode && ia >= (1 << (W - 1))) ia -= (1 << W);
    if (signed_mode && ib >= (1 << (W - 1))) ib -= (1 << W);
    if (ia < ib)  return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] cmp_of(input int g);
    return {t_less[g], t_equal[g], t_greater[g]};
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q0.push_back('{ref_cmp(a, b, 1'b0), a, b});
    exp_q1.push_back('{ref_cmp(a, b, 1'b1), a, b});
  endtask

  // Monitor: pops the scoreboard whenever an instance enters SHOW.
  initial begin
    exp_t e;
    logic [2:0] cur;
    for (int g = 0; g < 2; g++) begin
      prev_cmp[g] = '0;
      prev_wb[g] = 1'b0;
      leave_b_cyc[g] = -100;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < 2; g++) begin
        cur = cmp_of(g);
        if (rst) begin
          prev_cmp[g] = '0;
          prev_wb[g]  = 1'b0;
          continue;
        end
        if (prev_wb[g] && !t_wait_b[g]) leave_b_cyc[g] = cyc;
        if (cur != 3'b000 && prev_cmp[g] == 3'b000) begin
          if ((g == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            check(g == 0 ? "sb_unexpected_u" : "sb_unexpected_s", 32'(cur), 32'd0);
          end else begin
            e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(g == 0 ? "show_leds_u" : "show_leds_s", 32'(cur), 32'(e.leds));
            check(g == 0 ? "show_opnd_a_u" : "show_opnd_a_s", 32'(t_opnd_a[g]), 32'(e.a));
            check(g == 0 ? "show_opnd_b_u" : "show_opnd_b_s", 32'(t_opnd_b[g]), 32'(e.b));
            check(g == 0 ? "latency_u" : "latency_s", 32'(cyc - leave_b_cyc[g]), 32'd1);
          end
        end
        prev_cmp[g] = cur;
        prev_wb[g]  = t_wait_b[g];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic press_load(input logic [W-1:0] v);
    @(posedge clk); #1;
    sw = v;
    btn_load = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btn_load = 1'b0;
    sw = W'($urandom);  // switch noise outside a pulse must be ignored
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check({tag, "_cmp_leds"}, 32'(cmp_of(g)), 32'd0);
      check({tag, "_wait_a"}, 32'(t_wait_a[g]), 32'd1);
      check({tag, "_wait_b"}, 32'(t_wait_b[g]), 32'd0);
      check({tag, "_opnd_a"}, 32'(t_opnd_a[g]), 32'd0);
      check({tag, "_opnd_b"}, 32'(t_opnd_b[g]), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] pa[10];
    logic [W-1:0] pb[10];
    logic [W-1:0] ka;
    logic [W-1:0] kb;
    bit           found;

    pa[0] = 8'h05; pb[0] = 8'h0A;
    pa[1] = 8'h0A; pb[1] = 8'h0A;
    pa[2] = 8'hFF; pb[2] = 8'h01;
    pa[3] = 8'h80; pb[3] = 8'h7F;
    for (int i = 4; i < 10; i++) begin
      pa[i] = W'($urandom);
      pb[i] = (i == 5) ? pa[i] : W'($urandom);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Compare pairs, then leave SHOW with a further load
    for (int i = 0; i < 10; i++) begin
      press_load(pa[i]);
      for (int g = 0; g < 2; g++) begin
        check("after_a_wait_b", 32'(t_wait_b[g]), 32'd1);
        check("after_a_opnd_a", 32'(t_opnd_a[g]), 32'(pa[i]));
      end
      push_exp(pa[i], pb[i]);
      press_load(pb[i]);
      ka = t_opnd_a[0];
      kb = t_opnd_b[0];
      press_load(W'($urandom));
      for (int g = 0; g < 2; g++) begin
        check("show_exit_leds", 32'(cmp_of(g)), 32'd0);
        check("show_exit_wait_a", 32'(t_wait_a[g]), 32'd1);
        check("show_exit_opnd_a", 32'(t_opnd_a[g]), 32'(pa[i]));
        check("show_exit_opnd_b", 32'(t_opnd_b[g]), 32'(pb[i]));
      end
      check("show_exit_kept", 32'({ka, kb}), 32'({pa[i], pb[i]}));
    end

    // Bounce rejection: three 3-cycle glitches, then a real hold
    sw = 8'h33;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 btn_load = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check("bounce_no_advance", 32'(t_wait_a[g]), 32'd1);
    btn_load = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn_load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("bounce_one_advance", 32'(t_wait_b[g]), 32'd1);
      check("bounce_opnd_a", 32'(t_opnd_a[g]), 32'h33);
    end

    // Clear priority in WAIT_B
    @(posedge clk); #1;
    btn_load = 1'b1;
    btn_clear = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btn_load = 1'b0;
    btn_clear = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_reset_outputs("clear_prio");

    // Async reset mid-COMPARE, then a held button after release
    press_load(8'h5A);
    @(posedge clk); #1;
    sw = 8'h11;
    btn_load = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (!t_wait_a[0] && !t_wait_b[0] && cmp_of(0) == 3'b000) found = 1'b1;
    end
    check("reach_compare", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sw = 8'h77;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check("held_no_early_pulse", 32'(t_wait_a[g]), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (t_wait_b[0]) found = 1'b1;
    end
    check("held_pulse_seen", 32'(found), 32'd1);
    btn_load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("held_opnd_a", 32'(t_opnd_a[g]), 32'h77);
      check("held_single_pulse", 32'(t_wait_b[g]), 32'd1);
    end

    check("sb_drained_u", 32'(exp_q0.size()), 32'd0);
    check("sb_drained_s", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
